// File: rtl/src_stream_buffer.sv
// Source-filtered, in-order byte FIFO between the 4-source stimulus bus and the
// output monitor bus; emits one byte per pulse with a programmable minimum idle gap.
module src_stream_buffer #(
   parameter int DEPTH   = 16,
   parameter int OUT_GAP = 0,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   input  logic [1:0]               in_src,
   input  logic [3:0]               src_en,
   input  logic                     flush,
   output logic                     o_valid,
   output logic [7:0]               o_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int GW = (OUT_GAP > 0) ? $clog2(OUT_GAP + 1) : 1;
   localparam logic [PW:0]   FULL     = DEPTH[PW:0];
   localparam logic [GW-1:0] GAP_LOAD = OUT_GAP[GW-1:0];

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [GW-1:0] gap_cnt;
   logic          accept;
   logic          pop;
   logic          push;
   logic          drop;

   // A full FIFO still takes a byte when the head leaves on the same edge.
   always_comb begin
      accept = in_valid && src_en[in_src] && !flush;
      pop    = (level != '0) && (gap_cnt == '0) && !flush;
      push   = accept && ((level != FULL) || pop);
      drop   = accept && !push;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         gap_cnt <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         gap_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         level <= level + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
         if (pop)
            gap_cnt <= GAP_LOAD;
         else if (gap_cnt != '0)
            gap_cnt <= gap_cnt - GW'(1);
      end
   end

   // o_data holds the last emitted byte while o_valid is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         o_valid <= pop;
         if (pop) o_data <= mem[rd_ptr];
      end
   end

   // Flush clears the sticky flag but keeps the drop history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (flush)
            overflow <= 1'b0;
         else if (drop)
            overflow <= 1'b1;
         if (drop && (drop_cnt != '1))
            drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_src_stream_buffer.sv
// Bench for src_stream_buffer: two instances (OUT_GAP 0 and 3) share one stimulus
// stream; a queue model checks every cycle, directed checks pin key values.
module tb_src_stream_buffer;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic [1:0] in_src = '0;
   logic [3:0] src_en = 4'hF;
   logic       flush = 1'b0;

   logic        g0_valid, g3_valid, g0_ovf, g3_ovf;
   logic [7:0]  g0_data, g3_data;
   logic [4:0]  g0_level, g3_level;
   logic [15:0] g0_drop, g3_drop;

   int total = 0;
   int bad = 0;

   src_stream_buffer #(.DEPTH(DEPTH), .OUT_GAP(0), .CNT_W(16)) u_g0 (
      .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_data(in_data), .in_src(in_src),
      .src_en(src_en), .flush(flush), .o_valid(g0_valid), .o_data(g0_data),
      .level(g0_level), .overflow(g0_ovf), .drop_cnt(g0_drop));

   src_stream_buffer #(.DEPTH(DEPTH), .OUT_GAP(3), .CNT_W(16)) u_g3 (
      .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_data(in_data), .in_src(in_src),
      .src_en(src_en), .flush(flush), .o_valid(g3_valid), .o_data(g3_data),
      .level(g3_level), .overflow(g3_ovf), .drop_cnt(g3_drop));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Queue model: index 0 has gap 0, index 1 has gap 3.
   logic [7:0] mbuf [2][DEPTH];
   int         mcnt [2];
   int         mgap [2];
   logic       mv   [2];
   logic [7:0] md   [2];
   int         mdrop[2];
   logic       movf [2];

   task automatic model_step();
      logic acc;
      int   g;
      acc = in_valid && src_en[in_src] && !flush;
      for (int i = 0; i < 2; i++) begin
         g = (i == 0) ? 0 : 3;
         if (!rst_n) begin
            mcnt[i] = 0; mgap[i] = 0; mv[i] = 1'b0; md[i] = '0; mdrop[i] = 0; movf[i] = 1'b0;
         end else if (flush) begin
            mcnt[i] = 0; mgap[i] = 0; mv[i] = 1'b0; movf[i] = 1'b0;
         end else begin
            mv[i] = 1'b0;
            if (mcnt[i] > 0 && mgap[i] == 0) begin
               mv[i] = 1'b1;
               md[i] = mbuf[i][0];
               for (int k = 0; k < DEPTH - 1; k++) mbuf[i][k] = mbuf[i][k+1];
               mcnt[i]--;
               mgap[i] = g;
            end else if (mgap[i] > 0) begin
               mgap[i]--;
            end
            if (acc) begin
               if (mcnt[i] < DEPTH) begin
                  mbuf[i][mcnt[i]] = in_data;
                  mcnt[i]++;
               end else begin
                  if (mdrop[i] < 65535) mdrop[i]++;
                  movf[i] = 1'b1;
               end
            end
         end
      end
   endtask

   // Inputs change at negedge+1, so at negedge they are exactly what the last posedge saw.
   initial forever begin
      @(negedge clk);
      model_step();
      check("g0_valid", 32'(g0_valid), 32'(mv[0]));
      check("g0_data",  32'(g0_data),  32'(md[0]));
      check("g0_level", 32'(g0_level), 32'(mcnt[0]));
      check("g0_ovf",   32'(g0_ovf),   32'(movf[0]));
      check("g0_drop",  32'(g0_drop),  32'(mdrop[0]));
      check("g3_valid", 32'(g3_valid), 32'(mv[1]));
      check("g3_data",  32'(g3_data),  32'(md[1]));
      check("g3_level", 32'(g3_level), 32'(mcnt[1]));
      check("g3_ovf",   32'(g3_ovf),   32'(movf[1]));
      check("g3_drop",  32'(g3_drop),  32'(mdrop[1]));
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic f);
      in_valid = v; in_src = s; in_data = d; flush = f;
   endtask

   logic [7:0] t2_bytes [3] = '{8'h11, 8'h22, 8'h33};
   logic       rv [8];
   logic [7:0] rd [8];
   logic [7:0] pq [$];
   int         pidx [$];
   int         badgap;
   int         npulse;

   initial begin
      // Reset state
      drive(1'b0, 2'd0, 8'h00, 1'b0);
      repeat (3) tick();
      check("rst_g0_valid", 32'(g0_valid), 0);
      check("rst_g3_level", 32'(g3_level), 0);
      check("rst_g3_drop",  32'(g3_drop), 0);
      rst_n = 1'b1;

      // Latency and order, sources 0..2 back-to-back
      for (int i = 0; i < 6; i++) begin
         tick();
         rv[i] = g0_valid; rd[i] = g0_data;
         if (i < 3) drive(1'b1, 2'(i), t2_bytes[i], 1'b0);
         else       drive(1'b0, 2'd0, 8'h00, 1'b0);
      end
      check("lat_v0", 32'(rv[0]), 0);
      check("lat_v1", 32'(rv[1]), 0);
      check("lat_v2", 32'(rv[2]), 1);
      check("lat_d2", 32'(rd[2]), 32'h11);
      check("lat_d3", 32'(rd[3]), 32'h22);
      check("lat_d4", 32'(rd[4]), 32'h33);
      check("lat_v5", 32'(rv[5]), 0);
      repeat (20) tick();

      // Source filter
      src_en = 4'b0101;
      pq.delete();
      for (int i = 0; i < 8; i++) begin
         tick();
         if (g0_valid) pq.push_back(g0_data);
         if (i < 4) drive(1'b1, 2'(i), 8'hA0 + 8'(i), 1'b0);
         else       drive(1'b0, 2'd0, 8'h00, 1'b0);
      end
      check("filt_count", 32'(pq.size()), 2);
      if (pq.size() == 2) begin
         check("filt_b0", 32'(pq[0]), 32'hA0);
         check("filt_b1", 32'(pq[1]), 32'hA2);
      end
      check("filt_drop", 32'(g0_drop), 0);
      repeat (20) tick();
      src_en = 4'hF;

      // Overflow burst on the gap-3 instance; full push+pop at obs 22
      pq.delete(); pidx.delete();
      for (int i = 0; i < 124; i++) begin
         tick();
         if (g3_valid) begin
            pq.push_back(g3_data);
            pidx.push_back(i);
         end
         if (i == 22) begin
            check("full_level", 32'(g3_level), 16);
            check("full_drop",  32'(g3_drop), 0);
            check("full_valid", 32'(g3_valid), 1);
         end
         if (i == 24) begin
            check("ovf_drop", 32'(g3_drop), 2);
            check("ovf_flag", 32'(g3_ovf), 1);
            check("ovf_g0_drop", 32'(g0_drop), 0);
         end
         if (i < 24) drive(1'b1, 2'd0, 8'(i), 1'b0);
         else        drive(1'b0, 2'd0, 8'h00, 1'b0);
      end
      check("ovf_count", 32'(pq.size()), 22);
      badgap = 0;
      for (int k = 0; k < pq.size(); k++) begin
         if (pq[k] != 8'(k)) badgap++;
         if (k > 0 && pidx[k] - pidx[k-1] != 4) badgap++;
      end
      check("ovf_order_spacing", 32'(badgap), 0);

      // Flush with a same-cycle input byte
      for (int i = 0; i < 6; i++) begin
         tick();
         drive(1'b1, 2'd1, 8'hC0 + 8'(i), 1'b0);
      end
      tick();
      check("fl_pre_ovf", 32'(g3_ovf), 1);
      check("fl_pre_nonempty", 32'(g3_level != 0), 1);
      drive(1'b1, 2'd0, 8'hEE, 1'b1);
      tick();
      drive(1'b0, 2'd0, 8'h00, 1'b0);
      check("fl_level", 32'(g3_level), 0);
      check("fl_g0_level", 32'(g0_level), 0);
      check("fl_valid", 32'(g3_valid), 0);
      check("fl_ovf", 32'(g3_ovf), 0);
      check("fl_drop", 32'(g3_drop), 2);
      npulse = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (g3_valid || g0_valid) npulse++;
      end
      check("fl_no_output", 32'(npulse), 0);

      // Reset mid-traffic, then first-byte latency after release
      for (int i = 0; i < 5; i++) begin
         tick();
         drive(1'b1, 2'd3, 8'h70 + 8'(i), 1'b0);
      end
      tick();
      drive(1'b0, 2'd0, 8'h00, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mrst_level", 32'(g3_level), 0);
      check("mrst_valid", 32'(g3_valid), 0);
      check("mrst_data",  32'(g3_data), 0);
      check("mrst_drop",  32'(g3_drop), 0);
      check("mrst_ovf",   32'(g3_ovf), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         rv[i] = g0_valid; rd[i] = g0_data;
         if (i == 0) drive(1'b1, 2'd0, 8'h5A, 1'b0);
         else        drive(1'b0, 2'd0, 8'h00, 1'b0);
      end
      check("rel_v1", 32'(rv[1]), 0);
      check("rel_v2", 32'(rv[2]), 1);
      check("rel_d2", 32'(rd[2]), 32'h5A);
      check("rel_v3", 32'(rv[3]), 0);

      repeat (20) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
